vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the pixel clock: horizontal/vertical counters, active-low sync pulses, the active-video `blank` flag, and frame/line markers. It sits directly upstream of every sprite/ROM drawing stage, which consumes `DrawX`, `DrawY` and `blank` to index ROMs and gate RGB. The drawing stage reads its ROM on the falling edge of `vga_clk`, so `DrawX`/`DrawY` change only on rising edges and stay stable for a full cycle.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_wrap_counter.sv | 46 ++++
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants and shared helpers for the
// VGA timing generator and its counters.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FP_DEF      = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BP_DEF      = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FP_DEF      = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BP_DEF      = 33;

    localparam int unsigned H_TOTAL_DEF  = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF  = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int unsigned HS_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
    localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
    localparam int unsigned VS_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
    localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

    // Half-open window test: lo <= v < hi.
    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-N up-counter with enable. Exposes the next-state value so callers
// can register decodes that line up with the count shown on the same cycle.
module vga_wrap_counter #(
    parameter int unsigned N = 800,
    parameter int unsigned W = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_next_o,
    output logic         wrap_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count and terminal-count pulse.
    always_comb begin
        count_d = count_q;
        wrap_o  = 1'b0;
        if (en_i) begin
            if (count_q == W'(N - 1)) begin
                count_d = '0;
                wrap_o  = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters plus registered sync, blank and
// line/frame markers, all aligned to the DrawX/DrawY shown on the same cycle.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FP      = H_FP_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BP      = H_BP_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FP      = V_FP_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BP      = V_BP_DEF
) (
    input  logic        vga_clk,
    input  logic        reset,
    output coord_t      DrawX,
    output coord_t      DrawY,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        sync,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    coord_t x_q, x_d, y_q, y_d;
    logic   h_wrap, v_wrap;

    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_q, blank_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_count_q, frame_count_d;

    vga_wrap_counter #(
        .N (H_TOTAL),
        .W ($bits(coord_t))
    ) u_h_cnt (
        .clk_i        (vga_clk),
        .rst_i        (reset),
        .en_i         (1'b1),
        .count_o      (x_q),
        .count_next_o (x_d),
        .wrap_o       (h_wrap)
    );

    // Vertical counter advances only on the horizontal wrap, so its wrap
    // pulse already marks the end of a whole frame.
    vga_wrap_counter #(
        .N (V_TOTAL),
        .W ($bits(coord_t))
    ) u_v_cnt (
        .clk_i        (vga_clk),
        .rst_i        (reset),
        .en_i         (h_wrap),
        .count_o      (y_q),
        .count_next_o (y_d),
        .wrap_o       (v_wrap)
    );

    // Decode flags from the next coordinates so they register alongside them.
    always_comb begin
        hs_d          = 1'b1;
        vs_d          = 1'b1;
        blank_d       = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;

        hs_d          = ~in_window(x_d, HS_START, HS_END);
        vs_d          = ~in_window(y_d, VS_START, VS_END);
        blank_d       = (x_d < H_VIS_C) && (y_d < V_VIS_C);
        line_start_d  = (x_d == 10'd0);
        frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);

        if (v_wrap) begin
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    // Flag and frame counter registers.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign sync        = 1'b0;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line-level behaviour and a
// small-timing instance for whole-frame behaviour.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_d;
    logic rst_s;

    always #5 clk = ~clk;

    logic [9:0]  d_x, d_y, s_x, s_y;
    logic        d_hs, d_vs, d_blank, d_sync, d_ls, d_fs;
    logic        s_hs, s_vs, s_blank, s_sync, s_ls, s_fs;
    logic [15:0] d_fc, s_fc;

    vga_timing_gen dut_d (
        .vga_clk     (clk),
        .reset       (rst_d),
        .DrawX       (d_x),
        .DrawY       (d_y),
        .hs          (d_hs),
        .vs          (d_vs),
        .blank       (d_blank),
        .sync        (d_sync),
        .line_start  (d_ls),
        .frame_start (d_fs),
        .frame_count (d_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_VISIBLE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) dut_s (
        .vga_clk     (clk),
        .reset       (rst_s),
        .DrawX       (s_x),
        .DrawY       (s_y),
        .hs          (s_hs),
        .vs          (s_vs),
        .blank       (s_blank),
        .sync        (s_sync),
        .line_start  (s_ls),
        .frame_start (s_fs),
        .frame_count (s_fc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string pfx, input logic [9:0] x, input logic [9:0] y,
                               input logic hs_v, input logic vs_v, input logic blank_v,
                               input logic ls_v, input logic fs_v, input logic [15:0] fc);
        check({pfx, "_x"},     int'(x),       0);
        check({pfx, "_y"},     int'(y),       0);
        check({pfx, "_hs"},    int'(hs_v),    1);
        check({pfx, "_vs"},    int'(vs_v),    1);
        check({pfx, "_blank"}, int'(blank_v), 0);
        check({pfx, "_ls"},    int'(ls_v),    0);
        check({pfx, "_fs"},    int'(fs_v),    0);
        check({pfx, "_fc"},    int'(fc),      0);
    endtask

    int ex, ey, efc;
    int e_pos, e_hs, e_vs, e_blank, e_ls, e_fs, e_fc;
    int hs_low, vs_low, blank_cnt, ls_cnt, fs_cnt, hs_first, hs_last, fs_first;

    task automatic clear_stats();
        e_pos = 0; e_hs = 0; e_vs = 0; e_blank = 0; e_ls = 0; e_fs = 0; e_fc = 0;
        hs_low = 0; vs_low = 0; blank_cnt = 0; ls_cnt = 0; fs_cnt = 0;
        hs_first = -1; hs_last = -1; fs_first = -1;
    endtask

    initial begin
        rst_d = 1'b1;
        rst_s = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset("d_rst", d_x, d_y, d_hs, d_vs, d_blank, d_ls, d_fs, d_fc);
        check_reset("s_rst", s_x, s_y, s_hs, s_vs, s_blank, s_ls, s_fs, s_fc);
        check("d_sync", int'(d_sync), 0);
        rst_d = 1'b0;
        rst_s = 1'b0;

        // Default timing: two full lines after release, ending at (0,2).
        clear_stats();
        for (int k = 1; k <= 1600; k++) begin
            @(posedge clk);
            @(negedge clk);
            ex = k % 800;
            ey = k / 800;
            if (int'(d_x) != ex || int'(d_y) != ey) e_pos++;
            if (d_hs != !(ex >= 656 && ex < 752)) e_hs++;
            if (d_blank != (ex < 640 && ey < 480)) e_blank++;
            if (d_ls != (ex == 0)) e_ls++;
            if (!d_hs) hs_low++;
            if (!d_vs) vs_low++;
            if (d_blank) blank_cnt++;
            if (d_ls) ls_cnt++;
            if (d_fs) fs_cnt++;
            if (!d_hs && ey == 1) begin
                if (hs_first < 0) hs_first = ex;
                hs_last = ex;
            end
            if (k == 1) begin
                check("d_first_x", int'(d_x), 1);
                check("d_first_y", int'(d_y), 0);
                check("d_first_blank", int'(d_blank), 1);
                check("d_first_ls", int'(d_ls), 0);
            end
            if (k == 799) check("d_x_799", int'(d_x), 799);
            if (k == 800) begin
                check("d_wrap_x", int'(d_x), 0);
                check("d_wrap_y", int'(d_y), 1);
                check("d_wrap_ls", int'(d_ls), 1);
            end
        end
        check("d_pos_errs", e_pos, 0);
        check("d_hs_errs", e_hs, 0);
        check("d_blank_errs", e_blank, 0);
        check("d_ls_errs", e_ls, 0);
        check("d_hs_low_cycles", hs_low, 192);
        check("d_hs_first", hs_first, 656);
        check("d_hs_last", hs_last, 751);
        check("d_blank_cycles", blank_cnt, 1280);
        check("d_ls_pulses", ls_cnt, 2);
        check("d_fs_pulses", fs_cnt, 0);
        check("d_vs_low_cycles", vs_low, 0);

        // Default timing: asynchronous reset at (300,2).
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("d_pre_rst_x", int'(d_x), 300);
        check("d_pre_rst_y", int'(d_y), 2);
        #2 rst_d = 1'b1;
        #1 check_reset("d_midrst", d_x, d_y, d_hs, d_vs, d_blank, d_ls, d_fs, d_fc);
        @(posedge clk);
        @(negedge clk);
        rst_d = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("d_rel_x", int'(d_x), 1);
        check("d_rel_y", int'(d_y), 0);
        check("d_rel_blank", int'(d_blank), 1);
        check("d_rel_hs", int'(d_hs), 1);

        // Small timing: async reset mid-run, then three full frames.
        #2 rst_s = 1'b1;
        #1 check_reset("s_midrst", s_x, s_y, s_hs, s_vs, s_blank, s_ls, s_fs, s_fc);
        @(negedge clk);
        rst_s = 1'b0;
        clear_stats();
        for (int k = 1; k <= 252; k++) begin
            @(posedge clk);
            @(negedge clk);
            ex  = k % 12;
            ey  = (k / 12) % 7;
            efc = k / 84;
            if (int'(s_x) != ex || int'(s_y) != ey) e_pos++;
            if (s_hs != !(ex >= 9 && ex < 11)) e_hs++;
            if (s_vs != (ey != 5)) e_vs++;
            if (s_blank != (ex < 8 && ey < 4)) e_blank++;
            if (s_ls != (ex == 0)) e_ls++;
            if (s_fs != (ex == 0 && ey == 0)) e_fs++;
            if (int'(s_fc) != efc) e_fc++;
            if (!s_hs) hs_low++;
            if (!s_vs) vs_low++;
            if (s_blank) blank_cnt++;
            if (s_ls) ls_cnt++;
            if (s_fs) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
            end
            if (k == 84) begin
                check("s_f1_fs", int'(s_fs), 1);
                check("s_f1_fc", int'(s_fc), 1);
                check("s_f1_blank", int'(s_blank), 1);
            end
        end
        check("s_pos_errs", e_pos, 0);
        check("s_hs_errs", e_hs, 0);
        check("s_vs_errs", e_vs, 0);
        check("s_blank_errs", e_blank, 0);
        check("s_ls_errs", e_ls, 0);
        check("s_fs_errs", e_fs, 0);
        check("s_fc_errs", e_fc, 0);
        check("s_hs_low_cycles", hs_low, 42);
        check("s_vs_low_cycles", vs_low, 36);
        check("s_blank_cycles", blank_cnt, 96);
        check("s_ls_pulses", ls_cnt, 21);
        check("s_fs_pulses", fs_cnt, 3);
        check("s_fs_first", fs_first, 84);
        check("s_fc_end", int'(s_fc), 3);
        check("s_sync", int'(s_sync), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
